// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and sizing shared by the sequential ALU
package alu_seq_pkg;

    localparam int DATA_SIZE = 32;
    localparam int CMD_W     = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_MOV = 4'h0,
        CMD_ADD = 4'h1,
        CMD_SUB = 4'h2,
        CMD_MUL = 4'h3,
        CMD_DIV = 4'h4,
        CMD_SHL = 4'h5,
        CMD_SHR = 4'h6,
        CMD_SAR = 4'h7,
        CMD_AND = 4'h8,
        CMD_OR  = 4'h9,
        CMD_XOR = 4'hA
    } cmd_e;

    localparam int ALU_STATE_W = 2;

    typedef enum logic [ALU_STATE_W-1:0] {
        ALU_IDLE = 2'd0,
        ALU_EXEC = 2'd1,
        ALU_ITER = 2'd2,
        ALU_DONE = 2'd3
    } alu_state_e;

    function automatic logic is_iter(input logic [CMD_W-1:0] code);
        return (code == CMD_MUL) || (code == CMD_DIV);
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// rtl/alu_iter_core.sv - shared shift-add multiplier / restoring divider, one bit per cycle
module alu_iter_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              mode,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              last
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] m;
    logic              mode_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   add_a;
    logic [DATA_W:0]   add_b;
    logic [DATA_W+1:0] sum;
    logic [DATA_W-1:0] hi_n;
    logic [DATA_W-1:0] lo_n;

    // cnt parks at DATA_W when idle, so the core stops stepping on its own
    assign last = (cnt == CNT_W'(DATA_W));

    // mode_q=1 (divide) turns the shared adder into shifted - divisor; bit DATA_W+1 = no borrow
    always_comb begin
        shifted = {hi, lo[DATA_W-1]};
        add_a   = mode_q ? shifted : {1'b0, hi};
        add_b   = mode_q ? ~{1'b0, m} : {1'b0, m};
        sum     = {1'b0, add_a} + {1'b0, add_b} + (DATA_W+2)'(mode_q);
        hi_n    = hi;
        lo_n    = lo;
        if (mode_q) begin
            if (sum[DATA_W+1]) begin
                hi_n = sum[DATA_W-1:0];
                lo_n = {lo[DATA_W-2:0], 1'b1};
            end else begin
                hi_n = shifted[DATA_W-1:0];
                lo_n = {lo[DATA_W-2:0], 1'b0};
            end
        end else begin
            if (lo[0]) begin
                hi_n = sum[DATA_W:1];
                lo_n = {sum[0], lo[DATA_W-1:1]};
            end else begin
                hi_n = {1'b0, hi[DATA_W-1:1]};
                lo_n = {hi[0], lo[DATA_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
            mode_q <= 1'b0;
            cnt    <= CNT_W'(DATA_W);
        end else if (load) begin
            hi     <= '0;
            lo     <= op_a;
            m      <= op_b;
            mode_q <= mode;
            cnt    <= '0;
        end else if (!last) begin
            hi     <= hi_n;
            lo     <= lo_n;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle execute-stage ALU with start/busy/done handshake and flags
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_W  = DATA_SIZE,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        cmd_code,
    input  logic [DATA_W-1:0] src0,
    input  logic [DATA_W-1:0] src1,
    output logic              busy,
    output logic              next_state,
    output logic [DATA_W-1:0] dst,
    output logic [DATA_W-1:0] dst_h,
    output logic [3:0]        flags,
    output logic              div0
);

    logic [1:0]        rst_sync;
    logic              rst_core_n;
    alu_state_e        state;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] core_hi;
    logic [DATA_W-1:0] core_lo;
    logic              core_last;
    logic              core_load;
    logic              commit;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_hi;
    logic              r_c;
    logic              r_v;
    logic              r_ok;

    // assertion is immediate, release waits two clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_core_n = rst_sync[1];

    assign core_load = (state == ALU_IDLE) && start && is_iter(cmd_code);
    assign commit    = !abort && ((state == ALU_EXEC) || ((state == ALU_ITER) && core_last));

    alu_iter_core #(.DATA_W(DATA_W)) u_iter (
        .clk   (clk),
        .rst_n (rst_core_n),
        .load  (core_load),
        .mode  (cmd_code == CMD_DIV),
        .op_a  (src0),
        .op_b  (src1),
        .hi    (core_hi),
        .lo    (core_lo),
        .last  (core_last)
    );

    always_comb begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        diff  = {1'b0, a_q} - {1'b0, b_q};
        shamt = b_q[SHAMT_W-1:0];
        r_lo  = '0;
        r_hi  = '0;
        r_c   = 1'b0;
        r_v   = 1'b0;
        r_ok  = 1'b1;
        case (op_q)
            CMD_MOV: begin
                r_lo = a_q;
                r_hi = b_q;
            end
            CMD_ADD: begin
                r_lo = sum[DATA_W-1:0];
                r_hi = {{(DATA_W-1){1'b0}}, sum[DATA_W]};
                r_c  = sum[DATA_W];
                r_v  = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
            end
            CMD_SUB: begin
                r_lo = diff[DATA_W-1:0];
                r_hi = {DATA_W{diff[DATA_W]}};
                r_c  = diff[DATA_W];
                r_v  = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
            end
            CMD_MUL: begin
                r_lo = core_lo;
                r_hi = core_hi;
                r_c  = |core_hi;
            end
            CMD_DIV: begin
                r_lo = core_lo;
                r_hi = core_hi;
            end
            CMD_SHL: r_lo = a_q << shamt;
            CMD_SHR: r_lo = a_q >> shamt;
            CMD_SAR: r_lo = $signed(a_q) >>> shamt;
            CMD_AND: r_lo = a_q & b_q;
            CMD_OR:  r_lo = a_q | b_q;
            CMD_XOR: r_lo = a_q ^ b_q;
            default: r_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state      <= ALU_IDLE;
            busy       <= 1'b0;
            next_state <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            dst        <= '0;
            dst_h      <= '0;
            flags      <= '0;
            div0       <= 1'b0;
        end else begin
            next_state <= 1'b0;
            case (state)
                ALU_IDLE: begin
                    if (start) begin
                        op_q  <= cmd_code;
                        a_q   <= src0;
                        b_q   <= src1;
                        busy  <= 1'b1;
                        state <= is_iter(cmd_code) ? ALU_ITER : ALU_EXEC;
                    end
                end
                ALU_EXEC, ALU_ITER: begin
                    if (abort) begin
                        state <= ALU_IDLE;
                        busy  <= 1'b0;
                    end else if (commit) begin
                        state      <= ALU_DONE;
                        next_state <= 1'b1;
                    end
                end
                ALU_DONE: begin
                    state <= ALU_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ALU_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (commit) begin
                dst   <= r_lo;
                dst_h <= r_hi;
                flags <= r_ok ? {r_lo[DATA_W-1], (r_lo == '0), r_c, r_v} : 4'b0000;
                if (op_q == CMD_DIV) div0 <= (b_q == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  cmd_code;
    logic [31:0] src0;
    logic [31:0] src1;
    logic        busy;
    logic        next_state;
    logic [31:0] dst;
    logic [31:0] dst_h;
    logic [3:0]  flags;
    logic        div0;

    int checks = 0;
    int errors = 0;
    int lat;
    bit busy_ok;
    bit seen;
    bit hold_start;

    alu_seq #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cmd_code   (cmd_code),
        .src0       (src0),
        .src1       (src1),
        .busy       (busy),
        .next_state (next_state),
        .dst        (dst),
        .dst_h      (dst_h),
        .flags      (flags),
        .div0       (div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // latency counts rising edges from the accept edge to the edge raising next_state
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        cmd_code = c;
        src0     = a;
        src1     = b;
        start    = 1'b1;
        lat      = 0;
        busy_ok  = 1'b1;
        seen     = 1'b0;
        while (!seen && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (hold_start) begin
                cmd_code = CMD_ADD;
                src0     = 32'd1;
                src1     = 32'd1;
            end else begin
                start = 1'b0;
                src0  = ~a;
                src1  = ~b;
            end
            if (!busy) busy_ok = 1'b0;
            if (next_state) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        cmd_code   = 4'h0;
        src0       = '0;
        src1       = '0;
        hold_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ns", 64'(next_state), 64'd0);
        check("rst_dst", {dst_h, dst}, 64'd0);
        check("rst_flags_div0", {flags, div0}, 64'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        run_op(CMD_ADD, 32'hFFFF_FFFF, 32'd1);
        check("add_seen", 64'(seen), 64'd1);
        check("add_lat", 64'(lat), 64'd2);
        check("add_res", {dst_h, dst}, 64'h0000_0001_0000_0000);
        check("add_flags", 64'(flags), 64'b0110);

        run_op(CMD_SUB, 32'h8000_0000, 32'd1);
        check("sub_res", {dst_h, dst}, 64'h0000_0000_7FFF_FFFF);
        check("sub_flags", 64'(flags), 64'b0001);

        run_op(CMD_SUB, 32'd1, 32'd2);
        check("sub_borrow", {dst_h, dst}, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sub_borrow_flags", 64'(flags), 64'b1010);

        run_op(CMD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mul_lat", 64'(lat), 64'd34);
        check("mul_busy", 64'(busy_ok), 64'd1);
        check("mul_res", {dst_h, dst}, 64'hFFFF_FFFE_0000_0001);
        check("mul_flags", 64'(flags), 64'b0010);

        run_op(CMD_DIV, 32'd100, 32'd7);
        check("div_lat", 64'(lat), 64'd34);
        check("div_res", {dst_h, dst}, {32'd2, 32'd14});
        check("div_div0", 64'(div0), 64'd0);

        run_op(CMD_DIV, 32'd5, 32'd0);
        check("div0_lat", 64'(lat), 64'd34);
        check("div0_res", {dst_h, dst}, {32'd5, 32'hFFFF_FFFF});
        check("div0_flag", 64'(div0), 64'd1);

        run_op(CMD_SAR, 32'h8000_0000, 32'd4);
        check("sar_res", {dst_h, dst}, 64'h0000_0000_F800_0000);
        check("sar_flags", 64'(flags), 64'b1000);
        run_op(CMD_SHL, 32'h0000_0001, 32'h21);
        check("shl_wrap", 64'(dst), 64'h2);
        run_op(CMD_SHR, 32'h0000_1234, 32'h0);
        check("shr_zero", 64'(dst), 64'h1234);
        run_op(CMD_AND, 32'hFF00_FF00, 32'h0F0F_0F0F);
        check("and_res", {dst_h, dst}, 64'h0000_0000_0F00_0F00);
        run_op(CMD_OR, 32'hFF00_FF00, 32'h0F0F_0F0F);
        check("or_res", 64'(dst), 64'hFF0F_FF0F);
        run_op(CMD_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
        check("xor_res", 64'(dst), 64'hF00F_F00F);
        run_op(CMD_MOV, 32'hAAAA_5555, 32'h1234_5678);
        check("mov_res", {dst_h, dst}, 64'h1234_5678_AAAA_5555);
        check("mov_lat", 64'(lat), 64'd2);

        run_op(4'hF, 32'hDEAD_BEEF, 32'h1);
        check("undef_seen", 64'(seen), 64'd1);
        check("undef_res", {dst_h, dst}, 64'd0);
        check("undef_flags", 64'(flags), 64'd0);

        hold_start = 1'b1;
        run_op(CMD_MUL, 32'd3, 32'd5);
        hold_start = 1'b0;
        check("busy_start_lat", 64'(lat), 64'd34);
        check("busy_start_res", {dst_h, dst}, 64'd15);

        // abort a MUL part-way; the previous result must survive
        @(negedge clk);
        cmd_code = CMD_MUL;
        src0     = 32'd7;
        src1     = 32'd9;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (next_state) seen = 1'b1;
        end
        check("abort_no_pulse", 64'(seen), 64'd0);
        check("abort_keep", {dst_h, dst}, 64'd15);

        // reset in the middle of a DIV
        @(negedge clk);
        cmd_code = CMD_DIV;
        src0     = 32'd100;
        src1     = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_out", {dst_h, dst}, 64'd0);
        check("rst_mid_flags_div0", {flags, div0}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run_op(CMD_ADD, 32'd2, 32'd3);
        check("post_rst_add", {dst_h, dst}, 64'd5);
        check("post_rst_lat", 64'(lat), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
